// File: rtl/raw_hazard_detector.sv
// raw_hazard_detector
//
// Write pool and read-after-write hazard detector that sits in front of the
// raw data buffer. Pending DRAM writes wait in a small in-order pool until
// the command path drains them. Every read request is checked against the
// pool, and the result is registered one cycle later:
//   raw       - the youngest matching write covers every byte of the read.
//               The matching entry is forwarded on pool_waddr/pool_wdata.
//   raw_stall - the youngest matching write covers only some of the read
//               bytes. The read must retry after the write drains.
//
// Optional feature (build macro RAW_HIT_COUNT_EN):
//   This adds the raw_hit_count output, a 16-bit saturating count of
//   registered raw hits.
//
// Ports:
//   clk, n_rst                        clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/        write push into the pool
//     wr_data/wr_burst_size
//   drain_valid/drain_ready/          oldest entry, offered to the command path
//     drain_addr/drain_data/drain_burst_size
//   rd_req/raddr/rburst_size          read lookup request (one-cycle pulse)
//   raw/raw_stall                     registered hit / partial-hit flags
//   raddr_raw/rburst_size_raw         registered copy of the read request
//   pool_waddr/pool_wdata             registered winning entry (on raw only)
//   pool_count                        number of occupied entries
//   raw_hit_count                     (RAW_HIT_COUNT_EN only) hit counter

package raw_hazard_pkg;
  typedef enum logic [1:0] {
    ONE_BYTE    = 2'd0,
    TWO_BYTES   = 2'd1,
    FOUR_BYTES  = 2'd2,
    EIGHT_BYTES = 2'd3
  } burst_size_t;
endpackage

module raw_hazard_detector
  import raw_hazard_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_SIZE-1:0]   wr_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  burst_size_t            wr_burst_size,
  output logic                   drain_valid,
  input  logic                   drain_ready,
  output logic [ADDR_SIZE-1:0]   drain_addr,
  output logic [DATA_SIZE-1:0]   drain_data,
  output burst_size_t            drain_burst_size,
  input  logic                   rd_req,
  input  logic [ADDR_SIZE-1:0]   raddr,
  input  burst_size_t            rburst_size,
  output logic                   raw,
  output logic                   raw_stall,
  output logic [ADDR_SIZE-1:0]   raddr_raw,
  output burst_size_t            rburst_size_raw,
  output logic [ADDR_SIZE-1:0]   pool_waddr,
  output logic [DATA_SIZE-1:0]   pool_wdata,
  output logic [$clog2(DEPTH):0] pool_count
`ifdef RAW_HIT_COUNT_EN
  ,
  output logic [15:0]            raw_hit_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Byte-lane mask of an access. The lanes rotate inside the 64-bit word,
  // so an access that runs past byte 7 wraps back to byte 0.
  function automatic logic [7:0] byte_mask(input logic [2:0] off, input burst_size_t sz);
    logic [7:0]  base;
    logic [15:0] rot;
    case (sz)
      EIGHT_BYTES: base = 8'hFF;
      FOUR_BYTES:  base = 8'h0F;
      TWO_BYTES:   base = 8'h03;
      default:     base = 8'h01;
    endcase
    rot = {base, base} << off;
    return rot[15:8];
  endfunction

  // Pool storage. It has no reset: valid_reg is the source of truth.
  logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
  logic [DATA_SIZE-1:0] data_mem [DEPTH];
  burst_size_t          size_mem [DEPTH];
  logic [7:0]           wmask    [DEPTH];

  logic [DEPTH-1:0] valid_reg;
  logic [PW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             push, pop;

  assign wr_ready         = (count_reg != CW'(DEPTH));
  assign drain_valid      = (count_reg != '0);
  assign push             = wr_valid && wr_ready;
  assign pop              = drain_valid && drain_ready;
  assign drain_addr       = addr_mem[head_reg];
  assign drain_data       = data_mem[head_reg];
  assign drain_burst_size = size_mem[head_reg];
  assign pool_count       = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= wr_addr;
      data_mem[tail_reg] <= wr_data;
      size_mem[tail_reg] <= wr_burst_size;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      // A push never lands on the head slot while that slot is popped,
      // because a push is blocked when the pool is full.
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Per-entry write masks
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wmask
      assign wmask[gi] = byte_mask(addr_mem[gi][2:0], size_mem[gi]);
    end
  endgenerate

  // Lookup. Entries are scanned from oldest to youngest, and each later
  // match overrides an earlier one, so the youngest matching entry wins.
  // The scan reads register state, so a same-cycle push is not seen and a
  // same-cycle pop is still seen.
  logic [7:0]           rmask;
  logic                 hit, full_cover;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [DATA_SIZE-1:0] win_data;

  assign rmask = byte_mask(raddr[2:0], rburst_size);

  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    hit        = 1'b0;
    full_cover = 1'b0;
    win_addr   = '0;
    win_data   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PW'(k);
      if (valid_reg[idx] &&
          (addr_mem[idx][ADDR_SIZE-1:3] == raddr[ADDR_SIZE-1:3]) &&
          ((wmask[idx] & rmask) != 8'h00)) begin
        hit        = 1'b1;
        full_cover = ((rmask & ~wmask[idx]) == 8'h00);
        win_addr   = addr_mem[idx];
        win_data   = data_mem[idx];
      end
    end
  end

  logic raw_next, raw_stall_next;
  assign raw_next       = rd_req && hit && full_cover;
  assign raw_stall_next = rd_req && hit && !full_cover;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raw             <= 1'b0;
      raw_stall       <= 1'b0;
      raddr_raw       <= '0;
      rburst_size_raw <= ONE_BYTE;
      pool_waddr      <= '0;
      pool_wdata      <= '0;
    end else begin
      raw       <= raw_next;
      raw_stall <= raw_stall_next;
      if (rd_req) begin
        raddr_raw       <= raddr;
        rburst_size_raw <= rburst_size;
      end
      if (raw_next) begin
        pool_waddr <= win_addr;
        pool_wdata <= win_data;
      end
    end
  end

`ifdef RAW_HIT_COUNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raw_hit_count <= '0;
    end else if (raw_next && (raw_hit_count != 16'hFFFF)) begin
      raw_hit_count <= raw_hit_count + 16'd1;
    end
  end
`else
  // The hit counter is not built.
`endif

endmodule

// File: tb/tb_raw_hazard_detector.sv
// Directed testbench for raw_hazard_detector (DEPTH=4).
module tb_raw_hazard_detector;
  import raw_hazard_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  burst_size_t wr_burst_size;
  logic        drain_valid;
  logic        drain_ready;
  logic [7:0]  drain_addr;
  logic [63:0] drain_data;
  burst_size_t drain_burst_size;
  logic        rd_req;
  logic [7:0]  raddr;
  burst_size_t rburst_size;
  logic        raw;
  logic        raw_stall;
  logic [7:0]  raddr_raw;
  burst_size_t rburst_size_raw;
  logic [7:0]  pool_waddr;
  logic [63:0] pool_wdata;
  logic [2:0]  pool_count;
`ifdef RAW_HIT_COUNT_EN
  logic [15:0] raw_hit_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  raw_hazard_detector #(.ADDR_SIZE(8), .DATA_SIZE(64), .DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_burst_size(wr_burst_size),
    .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_burst_size(drain_burst_size),
    .rd_req(rd_req), .raddr(raddr), .rburst_size(rburst_size),
    .raw(raw), .raw_stall(raw_stall), .raddr_raw(raddr_raw),
    .rburst_size_raw(rburst_size_raw), .pool_waddr(pool_waddr),
    .pool_wdata(pool_wdata), .pool_count(pool_count)
`ifdef RAW_HIT_COUNT_EN
    , .raw_hit_count(raw_hit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [63:0] d, input burst_size_t s);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_burst_size = s;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a, input burst_size_t s);
    rd_req = 1'b1; raddr = a; rburst_size = s;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic pop_one();
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_burst_size = ONE_BYTE;
    drain_ready = 1'b0; rd_req = 1'b0; raddr = '0; rburst_size = ONE_BYTE;
    #2;
    check("reset_count", 64'(pool_count), 64'd0);
    check("reset_drain_valid", 64'(drain_valid), 64'd0);
    check("reset_raw", 64'(raw), 64'd0);
    check("reset_stall", 64'(raw_stall), 64'd0);
    check("reset_wdata", pool_wdata, 64'd0);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Single full-word push
    wr_valid = 1'b1; wr_addr = 8'h10; wr_data = 64'h0706050403020100; wr_burst_size = EIGHT_BYTES;
    #1 check("t1_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    check("t1_count", 64'(pool_count), 64'd1);
    check("t1_drain_valid", 64'(drain_valid), 64'd1);
    check("t1_drain_addr", 64'(drain_addr), 64'h10);
    check("t1_drain_data", drain_data, 64'h0706050403020100);
    $display("push 0x10 EIGHT -> count=%0d", pool_count);

    // A four-byte read inside that word is fully covered
    lookup(8'h12, FOUR_BYTES);
    check("t2_raw", 64'(raw), 64'd1);
    check("t2_stall", 64'(raw_stall), 64'd0);
    check("t2_waddr", 64'(pool_waddr), 64'h10);
    check("t2_wdata", pool_wdata, 64'h0706050403020100);
    check("t2_raddr_raw", 64'(raddr_raw), 64'h12);
    check("t2_rsize_raw", 64'(rburst_size_raw), 64'(FOUR_BYTES));
    $display("read 0x12 FOUR -> raw=%0b stall=%0b", raw, raw_stall);
    tick();
    check("t2_idle_raw", 64'(raw), 64'd0);
    check("t2_hold_wdata", pool_wdata, 64'h0706050403020100);
    pop_one();
    check("t2_drained", 64'(pool_count), 64'd0);

    // A single-byte write gives partial coverage
    push(8'h14, 64'h000000AA00000000, ONE_BYTE);
    lookup(8'h14, TWO_BYTES);
    check("t3_raw", 64'(raw), 64'd0);
    check("t3_stall", 64'(raw_stall), 64'd1);
    $display("read 0x14 TWO vs 0x14 ONE -> raw=%0b stall=%0b", raw, raw_stall);
    lookup(8'h13, TWO_BYTES);
    check("t3b_stall", 64'(raw_stall), 64'd1);
    lookup(8'h20, EIGHT_BYTES);
    check("t3_miss_raw", 64'(raw), 64'd0);
    check("t3_miss_stall", 64'(raw_stall), 64'd0);
    check("t3_miss_hold_waddr", 64'(pool_waddr), 64'h10);
    pop_one();

    // Two writes to the same word: the youngest one wins
    push(8'h08, 64'hAAAAAAAAAAAAAAAA, EIGHT_BYTES);
    push(8'h08, 64'hBBBBBBBBBBBBBBBB, EIGHT_BYTES);
    lookup(8'h08, EIGHT_BYTES);
    check("t4_raw", 64'(raw), 64'd1);
    check("t4_youngest", pool_wdata, 64'hBBBBBBBBBBBBBBBB);
    $display("read 0x08 with two pending -> wdata=%h", pool_wdata);
    pop_one();
    pop_one();
    check("t4_drained", 64'(pool_count), 64'd0);

    // A push in the same cycle as the read is not visible; the next read sees it
    wr_valid = 1'b1; wr_addr = 8'h30; wr_data = 64'h3030; wr_burst_size = EIGHT_BYTES;
    lookup(8'h30, EIGHT_BYTES);
    wr_valid = 1'b0;
    check("t4b_same_cycle_raw", 64'(raw), 64'd0);
    check("t4b_same_cycle_stall", 64'(raw_stall), 64'd0);
    // A pop in the same cycle as the read is still visible
    drain_ready = 1'b1;
    lookup(8'h30, EIGHT_BYTES);
    drain_ready = 1'b0;
    check("t4b_pop_visible_raw", 64'(raw), 64'd1);
    check("t4b_pop_visible_data", pool_wdata, 64'h3030);
    check("t4b_count", 64'(pool_count), 64'd0);

    // Fill the pool, then test the full condition and pointer wrap
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(8 * i), 64'(i + 1), EIGHT_BYTES);
    check("t5_full_count", 64'(pool_count), 64'd4);
    check("t5_full_ready", 64'(wr_ready), 64'd0);
    push(8'h80, 64'hDEAD, EIGHT_BYTES);
    check("t5_ignored_count", 64'(pool_count), 64'd4);
    check("t5_ignored_head", drain_data, 64'd1);
    // A pop while full does not let a simultaneous push in
    wr_valid = 1'b1; wr_addr = 8'h88; wr_data = 64'hBEEF;
    pop_one();
    wr_valid = 1'b0;
    check("t5_pop_count", 64'(pool_count), 64'd3);
    check("t5_pop_ready", 64'(wr_ready), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      check("t5_order", drain_data, 64'(i));
      pop_one();
    end
    push(8'h60, 64'd5, EIGHT_BYTES);
    check("t5_wrap_data", drain_data, 64'd5);
    check("t5_wrap_addr", 64'(drain_addr), 64'h60);
    pop_one();
    check("t5_wrap_empty", 64'(drain_valid), 64'd0);
    $display("fill/wrap sequence -> count=%0d", pool_count);

    // Asynchronous reset with three entries pending and raw set
    for (int i = 0; i < 3; i++) push(8'h50, 64'(16 + i), EIGHT_BYTES);
    lookup(8'h50, EIGHT_BYTES);
    check("t6_pre_raw", 64'(raw), 64'd1);
    check("t6_pre_count", 64'(pool_count), 64'd3);
    n_rst = 1'b0;
    #1;
    check("t6_rst_count", 64'(pool_count), 64'd0);
    check("t6_rst_drain_valid", 64'(drain_valid), 64'd0);
    check("t6_rst_raw", 64'(raw), 64'd0);
`ifdef RAW_HIT_COUNT_EN
    check("t6_rst_hits", 64'(raw_hit_count), 64'd0);
`endif
    #1 n_rst = 1'b1;
    tick();
    check("t6_post_count", 64'(pool_count), 64'd0);
    $display("reset mid-operation -> count=%0d raw=%0b", pool_count, raw);

    // Three hits after reset
    push(8'h60, 64'h6666, EIGHT_BYTES);
    for (int i = 0; i < 3; i++) begin
      lookup(8'h60, EIGHT_BYTES);
      check("t7_raw", 64'(raw), 64'd1);
    end
`ifdef RAW_HIT_COUNT_EN
    check("t7_hit_count", 64'(raw_hit_count), 64'd3);
`endif
    $display("three hits after reset -> raw=%0b", raw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
